// File: rtl/axi_stream_csum_appender.sv
// AXI-Stream checksum appender: forwards beats, keeps a modular sum of kept bytes per packet,
// optionally appends the inverted sum as a trailer beat. AXIS_CSUM_STATS_EN adds packet/beat counters.
module axi_stream_csum_appender #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    append_en,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH-1:0]   csum_out,
  output logic                    csum_valid
`ifdef AXIS_CSUM_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [31:0]             beat_count
`endif
);
  // state    | meaning
  // ST_DATA  | forwarding beats, input open
  // ST_CSUM  | input closed, draining output/skid of the packet's data
  // ST_TRAIL | trailer beat sits in the output register awaiting handshake
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_DATA, ST_CSUM, ST_TRAIL} state_t;

  state_t state, state_nxt;

  logic                  run_q;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [BYTES-1:0]      skid_keep;
  logic [BYTES-1:0]      skid_strb;
  logic                  skid_last;
  logic                  first_q;
  logic                  app_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] masked;
  logic [DATA_WIDTH-1:0] sum_nxt;
  logic                  push;
  logic                  pop;
  logic                  out_free;
  logic                  app_eff;
  logic                  fwd_last;
  logic                  load_trailer;

  assign push     = s_axis_tvalid && s_axis_tready;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign app_eff  = first_q ? append_en : app_q;
  assign fwd_last = s_axis_tlast && !app_eff;
  assign sum_nxt  = sum_q + masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < BYTES; i++)
      if (s_axis_tkeep[i]) masked[8*i +: 8] = s_axis_tdata[8*i +: 8];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_DATA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA:  if (push && s_axis_tlast && app_eff) state_nxt = ST_CSUM;
      ST_CSUM:  if (!skid_valid && out_free) state_nxt = ST_TRAIL;
      ST_TRAIL: if (pop) state_nxt = ST_DATA;
      default:  state_nxt = ST_DATA;
    endcase
  end

  // run_q keeps tready low while reset is held
  always_comb begin
    s_axis_tready = run_q && !skid_valid && (state == ST_DATA);
    load_trailer  = (state == ST_CSUM) && !skid_valid && out_free;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_q         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_strb     <= '0;
      skid_last     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (out_free) begin
        if (skid_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= skid_data;
          m_axis_tkeep  <= skid_keep;
          m_axis_tstrb  <= skid_strb;
          m_axis_tlast  <= skid_last;
          skid_valid    <= 1'b0;
        end else if (push) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tkeep  <= s_axis_tkeep;
          m_axis_tstrb  <= s_axis_tstrb;
          m_axis_tlast  <= fwd_last;
        end else if (load_trailer) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= csum_out;
          m_axis_tkeep  <= '1;
          m_axis_tstrb  <= '1;
          m_axis_tlast  <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (push) begin
        skid_valid <= 1'b1;
        skid_data  <= s_axis_tdata;
        skid_keep  <= s_axis_tkeep;
        skid_strb  <= s_axis_tstrb;
        skid_last  <= fwd_last;
      end
    end
  end

  // csum_out is stable until the trailer is loaded, so it doubles as the trailer source
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      first_q    <= 1'b1;
      app_q      <= 1'b0;
      sum_q      <= '0;
      csum_out   <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= 1'b0;
      if (push) begin
        if (first_q) app_q <= append_en;
        first_q <= s_axis_tlast;
        if (s_axis_tlast) begin
          sum_q      <= '0;
          csum_out   <= ~sum_nxt;
          csum_valid <= 1'b1;
        end else begin
          sum_q <= sum_nxt;
        end
      end
    end
  end

`ifdef AXIS_CSUM_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (pop) begin
      beat_count <= beat_count + 32'd1;
      if (m_axis_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule
